// File: rtl/rv32i_fetch_if.sv
// Instruction-memory bus between the fetch unit and instruction memory.
// Signal names are seen from the fetch unit:
//   o_iaddr    : word address of the outstanding request (bits [1:0] = 0)
//   o_stb_inst : request strobe
//   i_ack_inst : memory acknowledge; qualifies i_inst for o_iaddr of that cycle
//   i_inst     : instruction word returned by memory
// master = fetch unit, slave = instruction memory.
interface rv32i_fetch_if;
  logic [31:0] o_iaddr;
  logic        o_stb_inst;
  logic        i_ack_inst;
  logic [31:0] i_inst;

  modport master (
    output o_iaddr,
    output o_stb_inst,
    input  i_ack_inst,
    input  i_inst
  );

  modport slave (
    input  o_iaddr,
    input  o_stb_inst,
    output i_ack_inst,
    output i_inst
  );
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage with a one-entry skid buffer.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   imem (master)      : instruction-memory request/ack bus (o_iaddr, o_stb_inst,
//                        i_ack_inst, i_inst)
//   o_inst, o_pc       : instruction and its address towards decode
//   o_valid            : o_inst/o_pc hold a live instruction
//   i_stall            : decode cannot accept; output slot is held
//   i_flush, i_next_pc : redirect request and its target (low bits ignored)
// A zero-wait memory can stream one instruction per cycle. When an ack lands
// while decode is stalled, the word is parked in the skid buffer and requests
// pause until decode drains it, so at most one instruction is ever buffered.
module rv32i_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv32i_fetch_if.master        imem,
  output logic [31:0]          o_inst,
  output logic [31:0]          o_pc,
  output logic                 o_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [31:0]          i_next_pc
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] PC_RESET_A = {PC_RESET[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        stb_q, stb_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        ack_s;
  logic [31:0] mem_inst_s;
  logic        slot_free_s;

  assign ack_s       = imem.i_ack_inst;
  assign mem_inst_s  = imem.i_inst;
  // The output slot can take a new instruction if it is empty or being consumed.
  assign slot_free_s = !valid_q || !i_stall;

  // Next-state and datapath selection; flush overrides everything else.
  always_comb begin
    state_d     = state_q;
    iaddr_d     = iaddr_q;
    stb_d       = stb_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (i_flush) begin
      // Any ack in this cycle belongs to the old stream and is dropped.
      state_d     = FETCH;
      stb_d       = 1'b1;
      valid_d     = 1'b0;
      iaddr_d     = {i_next_pc[31:2], 2'b00};
      skid_inst_d = NOP;
      skid_pc_d   = PC_RESET_A;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FETCH;
          stb_d   = 1'b1;
          iaddr_d = PC_RESET_A;
        end
        FETCH: begin
          if (ack_s) begin
            iaddr_d = iaddr_q + 32'd4;
            if (slot_free_s) begin
              inst_d  = mem_inst_s;
              pc_d    = iaddr_q;
              valid_d = 1'b1;
            end else begin
              // Decode is stalled: park the word and stop requesting.
              skid_inst_d = mem_inst_s;
              skid_pc_d   = iaddr_q;
              state_d     = SKID;
              stb_d       = 1'b0;
            end
          end else if (slot_free_s) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        SKID: begin
          if (!i_stall) begin
            inst_d  = skid_inst_q;
            pc_d    = skid_pc_q;
            valid_d = 1'b1;
            state_d = FETCH;
            stb_d   = 1'b1;
          end else begin
            state_d = SKID;
          end
        end
        default: begin
          state_d = IDLE;
          stb_d   = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iaddr_q     <= PC_RESET_A;
      stb_q       <= 1'b0;
      inst_q      <= NOP;
      pc_q        <= PC_RESET_A;
      valid_q     <= 1'b0;
      skid_inst_q <= NOP;
      skid_pc_q   <= PC_RESET_A;
    end else begin
      state_q     <= state_d;
      iaddr_q     <= iaddr_d;
      stb_q       <= stb_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign imem.o_iaddr    = iaddr_q;
  assign imem.o_stb_inst = stb_q;
  assign o_inst          = inst_q;
  assign o_pc            = pc_q;
  assign o_valid         = valid_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: directed scenarios followed by random
// ack/stall/flush traffic, all compared with a queue-based reference model.
module tb_rv32i_fetch;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_next_pc;

  int checks;
  int failures;

  rv32i_fetch_if mem_if ();

  rv32i_fetch #(.PC_RESET(PC_RESET)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem      (mem_if),
    .o_inst    (o_inst),
    .o_pc      (o_pc),
    .o_valid   (o_valid),
    .i_stall   (i_stall),
    .i_flush   (i_flush),
    .i_next_pc (i_next_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: instructions accepted from memory wait in a FIFO until
  // the decode slot takes them; requests are only issued while it is empty.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        m_fifo[$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_addr;
  logic        m_req;
  logic        m_idle;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_valid = 1'b0;
    m_pc    = PC_RESET;
    m_inst  = 32'h0000_0013;
    m_addr  = PC_RESET;
    m_req   = 1'b0;
    m_idle  = 1'b1;
  endtask

  task automatic model_step(input logic ack, input logic stall, input logic flush,
                            input logic [31:0] npc);
    logic take;
    ent_t e;
    take = !m_valid || !stall;
    if (flush) begin
      m_fifo.delete();
      m_valid = 1'b0;
      m_addr  = npc & 32'hFFFF_FFFC;
      m_req   = 1'b1;
      m_idle  = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_addr = PC_RESET;
      m_req  = 1'b1;
    end else begin
      if (m_req && ack) begin
        m_fifo.push_back('{pc: m_addr, inst: mem_word(m_addr)});
        m_addr = m_addr + 32'd4;
      end
      if (take) begin
        if (m_fifo.size() > 0) begin
          e       = m_fifo.pop_front();
          m_valid = 1'b1;
          m_pc    = e.pc;
          m_inst  = e.inst;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_req = (m_fifo.size() == 0);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("stb", {31'd0, mem_if.o_stb_inst}, {31'd0, m_req});
    chk("iaddr", mem_if.o_iaddr, m_addr);
    if (m_valid) begin
      chk("pc", o_pc, m_pc);
      chk("inst", o_inst, m_inst);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_stb"}, {31'd0, mem_if.o_stb_inst}, 32'd0);
    chk({tag, "_iaddr"}, mem_if.o_iaddr, PC_RESET);
    chk({tag, "_pc"}, o_pc, PC_RESET);
    chk({tag, "_inst"}, o_inst, 32'h0000_0013);
  endtask

  // One clock: memory answers the current request if ack_en, then compare.
  task automatic cycle(input logic ack_en, input logic stall, input logic flush,
                       input logic [31:0] npc);
    logic ack;
    ack = ack_en && mem_if.o_stb_inst;
    mem_if.i_ack_inst = ack;
    mem_if.i_inst     = ack ? mem_word(mem_if.o_iaddr) : $urandom();
    i_stall   = stall;
    i_flush   = flush;
    i_next_pc = npc;
    model_step(ack, stall, flush, npc);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic scramble_inputs();
    mem_if.i_ack_inst = 1'($urandom());
    mem_if.i_inst     = $urandom();
    i_stall           = 1'($urandom());
    i_flush           = 1'($urandom());
    i_next_pc         = $urandom();
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    mem_if.i_ack_inst = 1'b0;
    mem_if.i_inst     = 32'd0;
    i_stall   = 1'b0;
    i_flush   = 1'b0;
    i_next_pc = 32'd0;
    model_reset();

    // Reset takes effect without a clock and ignores the other inputs.
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst_async");
    for (int i = 0; i < 3; i++) begin
      scramble_inputs();
      @(posedge clk);
    end
    #1 check_reset_values("rst_held");
    rst_n = 1'b1;

    // Streaming with an ack every cycle.
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("first_iaddr", mem_if.o_iaddr, PC_RESET);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("stream_pc0", o_pc, 32'h0000_0000);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("stream_pc4", o_pc, 32'h0000_0004);

    // Stall while the ack of 0x8 arrives: word goes to the skid buffer.
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("skid_stb", {31'd0, mem_if.o_stb_inst}, 32'd0);
    chk("skid_pc_held", o_pc, 32'h0000_0004);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("skid_drain_pc", o_pc, 32'h0000_0008);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("after_skid_pc", o_pc, 32'h0000_000C);

    // Flush with a simultaneous ack of 0x10.
    n = 0;
    while (mem_if.o_iaddr != 32'h0000_0010 && n < 20) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      n++;
    end
    chk("reach_0x10", mem_if.o_iaddr, 32'h0000_0010);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_iaddr", mem_if.o_iaddr, 32'h0000_0100);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("flush_target_pc", o_pc, 32'h0000_0100);

    // Flush while the skid buffer is full and decode is stalled.
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    chk("skid_flush_valid", {31'd0, o_valid}, 32'd0);
    chk("skid_flush_iaddr", mem_if.o_iaddr, 32'h0000_0200);
    chk("skid_flush_stb", {31'd0, mem_if.o_stb_inst}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("skid_flush_pc", o_pc, 32'h0000_0200);

    // Address wrap-around.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_pc_top", o_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_pc_zero", o_pc, 32'h0000_0000);

    // Asynchronous reset in the middle of a stall.
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_midstall");
    for (int i = 0; i < 2; i++) begin
      scramble_inputs();
      @(posedge clk);
    end
    #1 rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("rerst_iaddr", mem_if.o_iaddr, PC_RESET);
    chk("rerst_stb", {31'd0, mem_if.o_stb_inst}, 32'd1);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            $urandom_range(0, 24) == 0, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
